// File: rtl/mem_arbiter.sv
// Two-port front end for the single-ported data memory.
// Arbitrates fetch vs. load/store, maps byte addresses onto word address plus
// byte controls, and sequences the memory's command / one-cycle read latency.
module mem_arbiter #(
  parameter int MEM_WORDS     = 64,
  parameter bit DATA_PRIORITY = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [15:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_byte,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        d_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic        mem_byte_enable,
  output logic        mem_byte_select,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out,
  input  logic        mem_wait
);

  typedef enum logic [1:0] {IDLE, CMD, RESP, ACK} state_t;

  localparam logic [16:0] WORD_LIMIT = 17'(MEM_WORDS);

  state_t state;
  logic   grant_data;  // 1 = data port owns the current transaction
  logic   rr_data;     // 1 = data port wins the next tie (round-robin mode)
  logic   sel_data;
  logic   sel_oor;

  function automatic logic out_of_range(input logic [15:0] byte_addr);
    return {2'b00, byte_addr[15:1]} >= WORD_LIMIT;
  endfunction

  // Stores return zero; byte loads keep only the low byte the memory returns.
  function automatic logic [15:0] load_data(input logic        is_store,
                                            input logic        is_byte,
                                            input logic [15:0] raw);
    if (is_store)     return 16'h0000;
    else if (is_byte) return {8'h00, raw[7:0]};
    else              return raw;
  endfunction

  // Pick the winner among the current requests and check its address range.
  always_comb begin
    sel_data = d_req && (!if_req || DATA_PRIORITY || rr_data);
    sel_oor  = sel_data ? out_of_range(d_addr) : out_of_range(if_addr);
  end

  // Transaction sequencer with registered memory command and acks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      grant_data      <= 1'b0;
      rr_data         <= 1'b1;
      if_ack          <= 1'b0;
      if_rdata        <= 16'h0000;
      d_ack           <= 1'b0;
      d_rdata         <= 16'h0000;
      d_err           <= 1'b0;
      mem_en          <= 1'b0;
      mem_we          <= 1'b0;
      mem_byte_enable <= 1'b0;
      mem_byte_select <= 1'b0;
      mem_addr        <= 16'h0000;
      mem_data_in     <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            grant_data <= sel_data;
            if (if_req && d_req) rr_data <= !sel_data;
            if (sel_oor) begin
              // Out-of-range: never touch the memory, complete next cycle.
              state <= ACK;
              if (sel_data) begin
                d_ack   <= 1'b1;
                d_err   <= 1'b1;
                d_rdata <= 16'h0000;
              end else begin
                if_ack   <= 1'b1;
                if_rdata <= 16'h0000;
              end
            end else begin
              state  <= CMD;
              mem_en <= 1'b1;
              if (sel_data) begin
                mem_addr        <= {1'b0, d_addr[15:1]};
                mem_we          <= d_we;
                mem_byte_enable <= d_byte;
                mem_byte_select <= d_byte & d_addr[0];
                mem_data_in     <= d_wdata;
              end else begin
                mem_addr        <= {1'b0, if_addr[15:1]};
                mem_we          <= 1'b0;
                mem_byte_enable <= 1'b0;
                mem_byte_select <= 1'b0;
                mem_data_in     <= 16'h0000;
              end
            end
          end
        end
        CMD: begin
          // Command stays frozen while the memory stalls.
          if (!mem_wait) begin
            mem_en <= 1'b0;
            state  <= RESP;
          end
        end
        RESP: begin
          if (grant_data) begin
            d_rdata <= load_data(mem_we, mem_byte_enable, mem_data_out);
            d_ack   <= 1'b1;
          end else begin
            if_rdata <= load_data(1'b0, 1'b0, mem_data_out);
            if_ack   <= 1'b1;
          end
          state <= ACK;
        end
        ACK: begin
          if_ack <= 1'b0;
          d_ack  <= 1'b0;
          d_err  <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port front end for the single-ported on-chip data memory. It arbitrates between the instruction-fetch port and the load/store data port, and converts byte addresses into the memory's word address plus byte_select/byte_enable. It sequences the memory's registered-address, one-cycle read latency and its wait line. Each requester gets a one-cycle ack carrying the read data.

Parameters:
MEM_WORDS, 64, word capacity of the memory; word addresses >= MEM_WORDS are out of range.
DATA_PRIORITY, 1, 1 = data port always wins a tie; 0 = round-robin on ties, with the first tie after reset going to data.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
if_req  input  1  fetch request; held high until if_ack is seen
if_addr  input  16  fetch byte address; bit 0 ignored
if_ack  output  1  one-cycle fetch completion
if_rdata  output  16  fetched word; valid while if_ack=1
d_req  input  1  data request; held high until d_ack is seen
d_we  input  1  1 = store, 0 = load
d_byte  input  1  1 = byte access, 0 = word access
d_addr  input  16  data byte address
d_wdata  input  16  store data; byte stores use bits [7:0]
d_ack  output  1  one-cycle data completion
d_rdata  output  16  load data, zero-extended for bytes; valid while d_ack=1
d_err  output  1  pulses with d_ack when the access was out of range
mem_en  output  1  memory command strobe
mem_we  output  1  memory write enable
mem_byte_enable  output  1  memory byte mode
mem_byte_select  output  1  1 = high byte, 0 = low byte
mem_addr  output  16  word address, equal to byte address >> 1
mem_data_in  output  16  memory write data
mem_data_out  input  16  memory read data; valid the cycle after the command is accepted
mem_wait  input  1  1 = memory stall; command is held

Behaviour:
- Reset: FSM goes to IDLE. All outputs are 0: acks, d_err, mem_en, mem_we, byte controls, mem_addr, mem_data_in, and both rdata registers. The round-robin pointer is set so data wins the next tie.
- States and transitions:
  - IDLE: if any req is high, select a winner, register the mem_* command fields from the winner, record which port was granted, then go to CMD. If the winner is out of range, go to ACK instead with rdata=0.
  - CMD: mem_en=1 with the held command. If mem_wait=1, stay in CMD and keep every mem_* output stable. Otherwise the memory accepts the command at this edge; go to RESP.
  - RESP: mem_en=0. Capture mem_data_out into the granted port's rdata; for stores, capture 0. Go to ACK.
  - ACK: assert the granted port's ack for exactly one cycle, then go to IDLE.
- Latency: request seen in IDLE at cycle 0 gives ack in cycle 3 with no wait states. Each wait cycle adds 1. Out-of-range access gives ack in cycle 1.
- Throughput: the FSM is back in IDLE in cycle 4. A requester keeping req high after its ack starts a new transaction at that point.
- Address mapping:
  - Fetch: mem_addr = if_addr >> 1, byte_enable=0, we=0.
  - Data: mem_addr = d_addr >> 1, mem_byte_select = d_addr[0] when d_byte=1 (else 0), mem_byte_enable = d_byte, mem_we = d_we, mem_data_in = d_wdata.
  - A misaligned word access silently uses the word at addr >> 1.
- Range check: (addr >> 1) >= MEM_WORDS means mem_en is never asserted and no write occurs. Data port: d_err=1 alongside d_ack. Fetch port: no error output; returns 0.
- Arbitration:
  - Only one transaction is in flight; requests arriving while busy wait in IDLE.
  - DATA_PRIORITY=1: data wins every tie, so fetch can be starved by a continuous data stream.
  - DATA_PRIORITY=0: on a tie, the port not granted last wins. The pointer updates only on ties.
- Request inputs are sampled only in IDLE; changes during CMD/RESP/ACK are ignored.
- Reset mid-operation: the in-flight transaction is dropped with no ack. Requesters must reissue. A store already accepted by memory stays written.

Test Plan:
- Fetch read, memory word 3 = 16'hBEEF: if_req=1, if_addr=16'h0006, no wait -> mem_en=1 in cycle 1 with mem_addr=3; if_ack=1 in cycle 3 with if_rdata=16'hBEEF.
- Byte store then byte load: d_we=1, d_byte=1, d_addr=16'h0009, d_wdata=16'h00A5 -> mem_addr=4, byte_select=1, byte_enable=1, d_ack in cycle 3. Then a load of the same address -> d_rdata=16'h00A5.
- Tie, DATA_PRIORITY=1: if_req and d_req both high in the same cycle -> data acked cycle 3, fetch acked cycle 7. With DATA_PRIORITY=0, two successive ties are granted data first, then fetch.
- mem_wait held 2 cycles during CMD -> mem_en and mem_addr stay stable; ack arrives in cycle 5.
- Out of range: d_addr=16'h0080, d_we=1 -> mem_en never asserted; d_ack=1 and d_err=1 in cycle 1; memory unchanged.
- rst=1 in RESP -> no ack ever appears; all outputs 0 the next cycle; a reissued request completes normally.
